// File: rtl/pacman_pkg.sv
// Shared definitions for the pacman movement controller: grid size, tick coordinates,
// direction/state encodings and the one-tile step helper (edge wrap under PACMAN_CTRL_WRAP_EN).
package pacman_pkg;
  localparam int GRID_COLS = 40;
  localparam int GRID_ROWS = 30;
  localparam int TICK_X    = 0;
  localparam int TICK_Y    = 480;

  typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3} dir_e;
  typedef enum logic [1:0] {S_IDLE, S_Q_WANT, S_Q_CUR, S_COMMIT} state_e;

  typedef struct packed {
    logic       ok;
    logic [5:0] col;
    logic [4:0] row;
  } tile_t;

  // ok=0 means the step leaves the grid and must be resolved as a wall.
  function automatic tile_t step_tile(input logic [5:0] col, input logic [4:0] row, input dir_e dir);
    tile_t t;
    t.ok  = 1'b1;
    t.col = col;
    t.row = row;
    case (dir)
      DIR_UP: begin
        if (row == 5'd0) begin
`ifdef PACMAN_CTRL_WRAP_EN
          t.row = 5'(GRID_ROWS - 1);
`else
          t.ok = 1'b0;
`endif
        end else t.row = row - 5'd1;
      end
      DIR_DOWN: begin
        if (row == 5'(GRID_ROWS - 1)) begin
`ifdef PACMAN_CTRL_WRAP_EN
          t.row = 5'd0;
`else
          t.ok = 1'b0;
`endif
        end else t.row = row + 5'd1;
      end
      DIR_LEFT: begin
        if (col == 6'd0) begin
`ifdef PACMAN_CTRL_WRAP_EN
          t.col = 6'(GRID_COLS - 1);
`else
          t.ok = 1'b0;
`endif
        end else t.col = col - 6'd1;
      end
      default: begin
        if (col == 6'(GRID_COLS - 1)) begin
`ifdef PACMAN_CTRL_WRAP_EN
          t.col = 6'd0;
`else
          t.ok = 1'b0;
`endif
        end else t.col = col + 6'd1;
      end
    endcase
    return t;
  endfunction
endpackage

// File: rtl/frame_tick.sv
// Vblank-start tick: one registered pulse when the scan first reaches (TICK_X, TICK_Y).
module frame_tick
  import pacman_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [10:0] y,
  output logic        tick
);
  logic at_pt, at_pt_q, tick_q;

  assign at_pt = (x == 11'(TICK_X)) && (y == 11'(TICK_Y));
  assign tick  = tick_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      at_pt_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      at_pt_q <= at_pt;
      tick_q  <= at_pt & ~at_pt_q;
    end
  end
endmodule

// File: rtl/pacman_ctrl.sv
// Pacman tile-movement controller: frame-paced move attempts, map ROM queries for the
// wanted then current heading, and committed position. Edge wrap enabled by PACMAN_CTRL_WRAP_EN.
module pacman_ctrl
  import pacman_pkg::*;
#(
  parameter int FRAMES_PER_MOVE = 8,
  parameter int START_COL       = 19,
  parameter int START_ROW       = 22
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic [3:0]  btn,
  output logic        map_req,
  output logic [5:0]  map_col,
  output logic [4:0]  map_row,
  input  logic        map_ack,
  input  logic        map_wall,
  output logic [5:0]  pac_col,
  output logic [4:0]  pac_row,
  output logic [1:0]  pac_dir,
  output logic        moved
);
  localparam logic [7:0] CNT_LAST = 8'(FRAMES_PER_MOVE - 1);

  logic       tick, move_req;
  logic [7:0] cnt_q;
  dir_e       want_q, att_dir_q, pdir_q;
  state_e     state_q;
  logic       pend_q, req_q, moved_q;
  logic [5:0] mcol_q, pcol_q;
  logic [4:0] mrow_q, prow_q;
  tile_t      tw, tc;

  frame_tick u_tick (.clk(clk), .reset(reset), .x(x), .y(y), .tick(tick));

  assign move_req = tick && (cnt_q == CNT_LAST);
  assign tw       = step_tile(pcol_q, prow_q, want_q);
  assign tc       = step_tile(pcol_q, prow_q, pdir_q);

  assign map_req = req_q;
  assign map_col = mcol_q;
  assign map_row = mrow_q;
  assign pac_col = pcol_q;
  assign pac_row = prow_q;
  assign pac_dir = pdir_q;
  assign moved   = moved_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      want_q <= DIR_LEFT;
    end else begin
      if (tick) cnt_q <= (cnt_q == CNT_LAST) ? 8'd0 : cnt_q + 8'd1;
      if (btn[0])      want_q <= DIR_UP;
      else if (btn[1]) want_q <= DIR_DOWN;
      else if (btn[2]) want_q <= DIR_LEFT;
      else if (btn[3]) want_q <= DIR_RIGHT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pend_q    <= 1'b0;
      att_dir_q <= DIR_LEFT;
      req_q     <= 1'b0;
      mcol_q    <= '0;
      mrow_q    <= '0;
      pcol_q    <= 6'(START_COL);
      prow_q    <= 5'(START_ROW);
      pdir_q    <= DIR_LEFT;
      moved_q   <= 1'b0;
    end else begin
      moved_q <= 1'b0;
      if (move_req && state_q != S_IDLE) pend_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (move_req || pend_q) begin
            pend_q    <= 1'b0;
            att_dir_q <= want_q;
            if (tw.ok) begin
              state_q <= S_Q_WANT;
              req_q   <= 1'b1;
              mcol_q  <= tw.col;
              mrow_q  <= tw.row;
            end else if (want_q != pdir_q) begin
              state_q <= S_Q_CUR;
            end
          end
        end
        S_Q_WANT: begin
          if (map_ack) begin
            req_q <= 1'b0;
            if (!map_wall) begin
              state_q <= S_COMMIT;
              pcol_q  <= mcol_q;
              prow_q  <= mrow_q;
              pdir_q  <= att_dir_q;
              moved_q <= 1'b1;
            end else if (att_dir_q == pdir_q) state_q <= S_IDLE;
            else state_q <= S_Q_CUR;
          end
        end
        S_Q_CUR: begin
          // First cycle keeps map_req low so the previous ack cannot be reused.
          if (!req_q) begin
            if (tc.ok) begin
              req_q  <= 1'b1;
              mcol_q <= tc.col;
              mrow_q <= tc.row;
            end else state_q <= S_IDLE;
          end else if (map_ack) begin
            req_q <= 1'b0;
            if (!map_wall) begin
              state_q <= S_COMMIT;
              pcol_q  <= mcol_q;
              prow_q  <= mrow_q;
              moved_q <= 1'b1;
            end else state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
